adc_scan_scheduler: RTL and testbench
=====================================

Name: adc_scan_scheduler

Overview:
Sequences the 12-bit, 8-channel serial ADC frame engine through a start/done handshake.
Shares the converter between N_REQ on-demand requesters using round-robin arbitration.
When no request is pending, runs a background scan over the channels enabled in a mask.
Keeps a per-channel result bank for the rest of the design (motor/sensor logic).

Parameters:
N_REQ, 2, number of on-demand requesters (1..4)
SCAN_GAP, 1000, idle clk cycles enforced after each background-scan conversion before the next scan conversion
TIMEOUT, 256, max clk cycles in WAIT before abort (used only with ADC_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
scan_en  in  1  enables background scan
scan_mask  in  8  channel enable mask for the scan; bit i = channel i
req_valid  in  N_REQ  request per requester; held with req_ch until req_ready
req_ch  in  N_REQ*3  requested channel, requester r at bits [3r+2:3r]
req_ready  out  N_REQ  one-cycle grant pulse to the accepted requester
rsp_valid  out  N_REQ  one-cycle result pulse to the granted requester
rsp_data  out  12  result value, valid while any rsp_valid bit is high
conv_start  out  1  one-cycle start pulse to the frame engine
conv_ch  out  3  channel for the conversion, stable from conv_start until conv_done
conv_busy  in  1  frame engine busy; start is never issued while high
conv_done  in  1  one-cycle completion pulse from the frame engine
conv_data  in  12  conversion result, valid with conv_done
ch_data  out  96  result bank, channel i at [12i+11:12i]
ch_upd  out  8  one-cycle pulse when channel i of the bank is written
err_timeout  out  1  sticky timeout flag (ADC_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, immediate): FSM = IDLE; rr_ptr = 0; scan_ptr = 0; gap_cnt = 0.
- Reset also clears all outputs to 0, including ch_data and err_timeout. A conversion in flight is abandoned, and its later conv_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE -> ISSUE when conv_busy = 0 and a source is selected. Source priority:
  - any req_valid: round-robin, searching from rr_ptr upward with wrap;
  - otherwise a scan, when scan_en = 1, scan_mask != 0 and gap_cnt = 0.
- ISSUE (1 cycle):
  - conv_start = 1 and conv_ch latched.
  - For a request: req_ready[g] = 1 and rr_ptr <= g+1 (mod N_REQ).
  - Always -> WAIT.
- WAIT: hold until conv_done = 1 -> STORE. conv_done in any other state is ignored.
- STORE (1 cycle):
  - ch_data[conv_ch] <= conv_data; ch_upd[conv_ch] = 1.
  - For a request: rsp_valid[g] = 1 and rsp_data = conv_data.
  - For a scan: scan_ptr advances to the next set bit of scan_mask above conv_ch, wrapping 7 -> 0; gap_cnt <= SCAN_GAP.
  - -> IDLE.
- Latency: req_valid seen in IDLE at cycle t gives req_ready/conv_start at t+1. conv_done at cycle d gives rsp_valid at d+1.
- gap_cnt decrements every cycle while nonzero. Requests bypass the gap.
- Scan channel selection: first set bit of scan_mask at or above scan_ptr, with wrap. A mask change takes effect at the next selection.
- scan_mask = 0 or scan_en = 0: no scan conversions; requests are still served.
- Simultaneous requests: exactly one grant per conversion. The others wait, keeping req_valid high. No requester starves: it waits at most N_REQ-1 conversions behind other requesters.
- A request arriving during WAIT/STORE is not granted before the next IDLE cycle.
- A request for the same channel that the scan is converting is not merged; it gets its own conversion.

Optional Feature:
- Macro ADC_TIMEOUT_EN.
- Defined: a counter runs in WAIT. On reaching TIMEOUT without conv_done:
  - err_timeout <= 1 (sticky until reset);
  - the granted requester gets rsp_valid with rsp_data = 12'hFFF;
  - ch_data is not updated and ch_upd is not pulsed;
  - FSM -> IDLE.
- Not defined: WAIT waits indefinitely and err_timeout is tied 0.

Decomposition:
- Package adc_pkg holds:
  - N_CH = 8, CH_W = 3, DATA_W = 12;
  - typedef adc_ch_t and adc_data_t;
  - enum sched_state_t {IDLE, ISSUE, WAIT, STORE}.
- Sub-module rr_arbiter (N_REQ-wide, with pointer input and one-hot grant output), reusable for other shared resources.

Test Plan:
- Single request: req_valid[0] = 1, req_ch[0] = 5; engine returns 12'hA5C.
  -> req_ready[0] one cycle after request; conv_ch = 5; rsp_valid[0] with 12'hA5C one cycle after conv_done; ch_upd[5] pulses; ch_data[5] = 12'hA5C.
- Simultaneous requests: req0 ch 1, req1 ch 2, both held.
  -> grants in order r0, r1; then re-requests give r1 before r0 only if rr_ptr = 1; no double grant in any cycle.
- Scan: scan_en = 1, scan_mask = 8'b1000_0101, SCAN_GAP = 10.
  -> conv_ch sequence 0, 2, 7, 0 …; at least 10 idle cycles between scan starts; scan_mask = 0 -> no conv_start.
- Request during scan gap: a request arrives while gap_cnt = 8.
  -> conv_start next cycle regardless of the gap.
- Busy and reset: conv_busy held high -> no conv_start. Reset asserted in WAIT.
  -> all outputs 0 immediately; a following conv_done pulse gives no ch_upd or rsp_valid.
- With ADC_TIMEOUT_EN, TIMEOUT = 16, no conv_done.
  -> rsp_valid with 12'hFFF 16 cycles after conv_start; err_timeout = 1 until reset; ch_data unchanged.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the 8-channel, 12-bit ADC scheduler.
package adc_pkg;
  localparam int N_CH   = 8;
  localparam int CH_W   = 3;
  localparam int DATA_W = 12;

  typedef logic [CH_W-1:0]   adc_ch_t;
  typedef logic [DATA_W-1:0] adc_data_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} sched_state_t;

  // First channel enabled in mask at or above start, wrapping 7 -> 0.
  // Returns start unchanged when the mask is empty.
  function automatic adc_ch_t next_set_ch(input logic [N_CH-1:0] mask, input adc_ch_t start);
    adc_ch_t ch;
    logic    found;
    next_set_ch = start;
    found       = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      ch = start + adc_ch_t'(i);
      if (!found && mask[ch]) begin
        next_set_ch = ch;
        found       = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic found;

  // Two passes avoid a computed index: upper half from ptr first, then the wrapped part.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_scan_scheduler.sv
// Shares the ADC frame engine between round-robin requesters and a masked background scan.
// Define ADC_TIMEOUT_EN to abort conversions whose conv_done never arrives.
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int SCAN_GAP = 1000,
  parameter int TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic [N_CH-1:0]        scan_mask,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CH_W-1:0]  req_ch,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   conv_start,
  output logic [CH_W-1:0]        conv_ch,
  input  logic                   conv_busy,
  input  logic                   conv_done,
  input  logic [DATA_W-1:0]      conv_data,
  output logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_upd,
  output logic                   err_timeout
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(SCAN_GAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  sched_state_t                   state_q, state_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  adc_ch_t                        scan_ptr_q, scan_ptr_d;
  logic [GAP_W-1:0]               gap_q, gap_d;
  adc_ch_t                        ch_q, ch_d;
  logic                           src_req_q, src_req_d;
  logic [N_REQ-1:0]               gnt_q, gnt_d;
  adc_data_t                      res_q, res_d;
  logic [N_CH-1:0][DATA_W-1:0]    bank_q, bank_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
`ifdef ADC_TIMEOUT_EN
  logic                           err_q, err_d;
`endif

  logic [N_REQ-1:0] arb_gnt;
  adc_ch_t          arb_ch;
  logic [PTR_W-1:0] gnt_next;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_ch   = '0;
    gnt_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_ch = req_ch[CH_W*i +: CH_W];
      if (gnt_q[i])   gnt_next = PTR_W'((i + 1) % N_REQ);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    scan_ptr_d = scan_ptr_q;
    gap_d      = gap_q;
    ch_d       = ch_q;
    src_req_d  = src_req_q;
    gnt_d      = gnt_q;
    res_d      = res_q;
    bank_d     = bank_q;
    tmo_d      = tmo_q;
`ifdef ADC_TIMEOUT_EN
    err_d      = err_q;
`endif
    conv_start = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_data   = '0;
    ch_upd     = '0;

    if (gap_q != '0) gap_d = gap_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!conv_busy) begin
          if (|req_valid) begin
            state_d   = ISSUE;
            src_req_d = 1'b1;
            gnt_d     = arb_gnt;
            ch_d      = arb_ch;
          end else if (scan_en && (|scan_mask) && (gap_q == '0)) begin
            state_d   = ISSUE;
            src_req_d = 1'b0;
            gnt_d     = '0;
            ch_d      = next_set_ch(scan_mask, scan_ptr_q);
          end
        end
      end
      ISSUE: begin
        conv_start = 1'b1;
        tmo_d      = TMO_W'(TIMEOUT - 1);
        if (src_req_q) begin
          req_ready = gnt_q;
          rr_ptr_d  = gnt_next;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
        if (conv_done) begin
          res_d   = conv_data;
          state_d = STORE;
        end
`ifdef ADC_TIMEOUT_EN
        else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
          if (src_req_q) begin
            rsp_valid = gnt_q;
            rsp_data  = '1;
          end
        end
`endif
      end
      STORE: begin
        ch_upd       = N_CH'(1) << ch_q;
        bank_d[ch_q] = res_q;
        if (src_req_q) begin
          rsp_valid = gnt_q;
          rsp_data  = res_q;
        end else begin
          scan_ptr_d = next_set_ch(scan_mask, ch_q + 1'b1);
          gap_d      = GAP_W'(SCAN_GAP);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      scan_ptr_q <= '0;
      gap_q      <= '0;
      ch_q       <= '0;
      src_req_q  <= 1'b0;
      gnt_q      <= '0;
      res_q      <= '0;
      bank_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      scan_ptr_q <= scan_ptr_d;
      gap_q      <= gap_d;
      ch_q       <= ch_d;
      src_req_q  <= src_req_d;
      gnt_q      <= gnt_d;
      res_q      <= res_d;
      bank_q     <= bank_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef ADC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign conv_ch = ch_q;
  assign ch_data = bank_q;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a scripted frame-engine responder.
module tb_adc_scan_scheduler;
  localparam int N_REQ    = 2;
  localparam int SCAN_GAP = 10;
  localparam int TIMEOUT  = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 scan_en = 1'b0;
  logic [7:0]           scan_mask = '0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ*3-1:0]   req_ch = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     rsp_valid;
  logic [11:0]          rsp_data;
  logic                 conv_start;
  logic [2:0]           conv_ch;
  logic                 conv_busy = 1'b0;
  logic                 conv_done = 1'b0;
  logic [11:0]          conv_data = '0;
  logic [95:0]          ch_data;
  logic [7:0]           ch_upd;
  logic                 err_timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.N_REQ(N_REQ), .SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_mask(scan_mask),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .conv_start(conv_start),
    .conv_ch(conv_ch), .conv_busy(conv_busy), .conv_done(conv_done),
    .conv_data(conv_data), .ch_data(ch_data), .ch_upd(ch_upd),
    .err_timeout(err_timeout)
  );

  // Returns the number of falling edges until conv_start is seen, or -1 if none within lim.
  task automatic wait_start(input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Called at the ISSUE negedge; returns at the negedge of the STORE cycle.
  task automatic engine_done(input logic [11:0] d);
    @(negedge clk);
    conv_done = 1'b1;
    conv_data = d;
    @(negedge clk);
    conv_done = 1'b0;
    conv_data = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({conv_start, req_ready, rsp_valid, rsp_data, ch_upd, ch_data, conv_ch, err_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got start=%b rdy=%b rsp=%b data=%h upd=%h ch=%0d err=%b, want all 0",
               conv_start, req_ready, rsp_valid, rsp_data, ch_upd, conv_ch, err_timeout);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (conv_start !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_start: got conv_start=%b want 0", conv_start);
    end
  endtask

  task automatic test_single_request();
    req_ch    = {3'd0, 3'd5};
    req_valid = 2'b01;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 2'b01 || conv_start !== 1'b1 || conv_ch !== 3'd5) begin
      n_err++;
      $display("FAIL single_grant: got rdy=%b start=%b ch=%0d want rdy=01 start=1 ch=5",
               req_ready, conv_start, conv_ch);
    end
    req_valid = 2'b00;
    engine_done(12'hA5C);
    n_vec++;
    if (rsp_valid !== 2'b01 || rsp_data !== 12'hA5C || ch_upd !== 8'h20) begin
      n_err++;
      $display("FAIL single_rsp: got rsp=%b data=%h upd=%h want rsp=01 data=a5c upd=20",
               rsp_valid, rsp_data, ch_upd);
    end
    @(negedge clk);
    n_vec++;
    if (ch_data[60 +: 12] !== 12'hA5C || rsp_valid !== 2'b00 || ch_upd !== 8'h00) begin
      n_err++;
      $display("FAIL single_bank: got ch5=%h rsp=%b upd=%h want ch5=a5c rsp=00 upd=00",
               ch_data[60 +: 12], rsp_valid, ch_upd);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  set_tab [5];
    logic [1:0]  gnt_tab [5];
    logic [2:0]  ch_tab  [5];
    logic [11:0] dat_tab [5];
    int cyc;
    set_tab = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
    gnt_tab = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    ch_tab  = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
    dat_tab = '{12'h111, 12'h222, 12'h0A1, 12'h0B2, 12'h0C1};
    pulse_reset();
    req_ch = {3'd2, 3'd1};
    for (int s = 0; s < 5; s++) begin
      if (set_tab[s] != 2'b00) req_valid = set_tab[s];
      wait_start(10, cyc);
      n_vec++;
      if (cyc < 0 || req_ready !== gnt_tab[s] || conv_ch !== ch_tab[s]) begin
        n_err++;
        $display("FAIL rr_grant_%0d: got cyc=%0d rdy=%b ch=%0d want rdy=%b ch=%0d",
                 s, cyc, req_ready, conv_ch, gnt_tab[s], ch_tab[s]);
      end
      req_valid = req_valid & ~gnt_tab[s];
      engine_done(dat_tab[s]);
      n_vec++;
      if (rsp_valid !== gnt_tab[s] || rsp_data !== dat_tab[s]) begin
        n_err++;
        $display("FAIL rr_rsp_%0d: got rsp=%b data=%h want rsp=%b data=%h",
                 s, rsp_valid, rsp_data, gnt_tab[s], dat_tab[s]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_scan();
    logic [2:0] exp_ch [4];
    int cyc;
    exp_ch = '{3'd0, 3'd2, 3'd7, 3'd0};
    pulse_reset();
    scan_mask = 8'b1000_0101;
    scan_en   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(40, cyc);
      if (k > 0) begin
        n_vec++;
        if (cyc !== 12) begin
          n_err++;
          $display("FAIL scan_gap_%0d: got %0d cycles from store to start, want 12", k, cyc);
        end
      end
      n_vec++;
      if (cyc < 0 || conv_ch !== exp_ch[k] || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL scan_ch_%0d: got cyc=%0d ch=%0d rdy=%b want ch=%0d rdy=00",
                 k, cyc, conv_ch, req_ready, exp_ch[k]);
      end
      engine_done(12'h300 + 12'(k));
      n_vec++;
      if (ch_upd !== (8'b1 << exp_ch[k]) || rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL scan_store_%0d: got upd=%h rsp=%b want upd=%h rsp=00",
                 k, ch_upd, rsp_valid, 8'b1 << exp_ch[k]);
      end
    end
    // gap_cnt reads 10, 9, 8 on the next three cycles
    repeat (3) @(negedge clk);
    req_ch    = {3'd0, 3'd6};
    req_valid = 2'b01;
    @(negedge clk);
    n_vec++;
    if (conv_start !== 1'b1 || req_ready !== 2'b01 || conv_ch !== 3'd6) begin
      n_err++;
      $display("FAIL gap_bypass: got start=%b rdy=%b ch=%0d want start=1 rdy=01 ch=6",
               conv_start, req_ready, conv_ch);
    end
    req_valid = '0;
    engine_done(12'h666);
    n_vec++;
    if (rsp_valid !== 2'b01 || rsp_data !== 12'h666) begin
      n_err++;
      $display("FAIL gap_rsp: got rsp=%b data=%h want rsp=01 data=666", rsp_valid, rsp_data);
    end
    scan_mask = 8'h00;
    wait_start(60, cyc);
    n_vec++;
    if (cyc !== -1) begin
      n_err++;
      $display("FAIL scan_mask_zero: got conv_start after %0d cycles, want none", cyc);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_busy_reset();
    int cyc;
    conv_busy = 1'b1;
    req_ch    = {3'd4, 3'd0};
    req_valid = 2'b10;
    wait_start(20, cyc);
    n_vec++;
    if (cyc !== -1) begin
      n_err++;
      $display("FAIL busy_block: got conv_start after %0d cycles, want none", cyc);
    end
    conv_busy = 1'b0;
    wait_start(5, cyc);
    n_vec++;
    if (cyc !== 1 || req_ready !== 2'b10 || conv_ch !== 3'd4) begin
      n_err++;
      $display("FAIL busy_release: got cyc=%0d rdy=%b ch=%0d want cyc=1 rdy=10 ch=4",
               cyc, req_ready, conv_ch);
    end
    req_valid = '0;
    @(negedge clk);
    n_vec++;
    if (ch_data === '0) begin
      n_err++;
      $display("FAIL bank_before_reset: got ch_data=%h want nonzero", ch_data);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({conv_start, req_ready, rsp_valid, rsp_data, ch_upd, ch_data, conv_ch, err_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_in_wait: got start=%b rdy=%b rsp=%b upd=%h ch=%0d bank=%h want all 0",
               conv_start, req_ready, rsp_valid, ch_upd, conv_ch, ch_data);
    end
    @(negedge clk);
    reset = 1'b0;
    engine_done(12'h444);
    n_vec++;
    if (ch_upd !== 8'h00 || rsp_valid !== 2'b00 || rsp_data !== 12'h000) begin
      n_err++;
      $display("FAIL stale_done: got upd=%h rsp=%b data=%h want all 0", ch_upd, rsp_valid, rsp_data);
    end
    @(negedge clk);
    n_vec++;
    if (ch_data !== '0 || conv_start !== 1'b0) begin
      n_err++;
      $display("FAIL stale_bank: got bank=%h start=%b want 0 0", ch_data, conv_start);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int hits;
    pulse_reset();
    req_ch    = {3'd0, 3'd3};
    req_valid = 2'b01;
    wait_start(5, cyc);
    req_valid = '0;
    engine_done(12'h333);
    @(negedge clk);
    req_valid = 2'b01;
    wait_start(5, cyc);
    req_valid = '0;
`ifdef ADC_TIMEOUT_EN
    hits = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        hits = i;
        break;
      end
    end
    n_vec++;
    if (hits !== 16 || rsp_valid !== 2'b01 || rsp_data !== 12'hFFF || ch_upd !== 8'h00) begin
      n_err++;
      $display("FAIL timeout_rsp: got at=%0d rsp=%b data=%h upd=%h want at=16 rsp=01 data=fff upd=00",
               hits, rsp_valid, rsp_data, ch_upd);
    end
    @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b1 || ch_data[36 +: 12] !== 12'h333) begin
      n_err++;
      $display("FAIL timeout_flag: got err=%b ch3=%h want err=1 ch3=333", err_timeout, ch_data[36 +: 12]);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got err=%b want 1", err_timeout);
    end
`else
    hits = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || ch_upd !== 8'h00 || err_timeout !== 1'b0) hits++;
    end
    n_vec++;
    if (hits !== 0 || ch_data[36 +: 12] !== 12'h333) begin
      n_err++;
      $display("FAIL wait_forever: got %0d active cycles ch3=%h want 0 and ch3=333", hits, ch_data[36 +: 12]);
    end
`endif
    pulse_reset();
    @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b0 || conv_start !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_cleared: got err=%b start=%b want 0 0", err_timeout, conv_start);
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_simultaneous();
    test_scan();
    test_busy_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
